// File: rtl/bank_teller_scheduler_pkg.sv
// bank_pkg: shared types, sizing helpers and defaults for the branch queue blocks.
package bank_pkg;
  localparam int DEFAULT_QDEPTH = 7;
  localparam int DEFAULT_TICKET_W = 8;
  typedef enum logic {IDLE, ANNOUNCE} sched_state_t;
  function automatic int cw_f(input int qdepth);
    return $clog2(qdepth + 1);
  endfunction
  function automatic int tw_f(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/bank_teller_scheduler_if.sv
// bank_teller_scheduler_if: sensor/teller inputs and hall display outputs of the scheduler.
interface bank_teller_scheduler_if
  import bank_pkg::*;
#(
  parameter int N_TELLERS = 3,
  parameter int QDEPTH = DEFAULT_QDEPTH,
  parameter int TICKET_W = DEFAULT_TICKET_W
) ();
  localparam int CW = cw_f(QDEPTH);
  localparam int TW = tw_f(N_TELLERS);
  logic arrive;
  logic [N_TELLERS-1:0] teller_req;
  logic [CW-1:0] pcount;
  logic full;
  logic empty;
  logic overflow;
  logic [N_TELLERS-1:0] grant;
  logic call_valid;
  logic [TW-1:0] call_teller;
  logic [TICKET_W-1:0] call_ticket;
  modport master (
    output arrive, teller_req,
    input pcount, full, empty, overflow, grant, call_valid, call_teller, call_ticket
  );
  modport slave (
    input arrive, teller_req,
    output pcount, full, empty, overflow, grant, call_valid, call_teller, call_ticket
  );
endinterface

// File: rtl/bank_teller_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr.
module rr_arbiter
  import bank_pkg::*;
#(
  parameter int N = 3,
  parameter int TW = tw_f(N)
) (
  input  logic [N-1:0]  req,
  input  logic [TW-1:0] ptr,
  output logic [N-1:0]  gnt_onehot,
  output logic [TW-1:0] gnt_idx,
  output logic          any
);
  // Scan from farthest to nearest so the closest request to ptr wins.
  always_comb begin
    gnt_onehot = '0;
    gnt_idx = '0;
    any = |req;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        gnt_onehot = '0;
        gnt_onehot[(int'(ptr) + k) % N] = 1'b1;
        gnt_idx = TW'((int'(ptr) + k) % N);
      end
    end
  end
endmodule

// File: rtl/bank_teller_scheduler.sv
// bank_teller_scheduler: waiting-customer queue, round-robin teller calls and timed hall announcement.
module bank_teller_scheduler
  import bank_pkg::*;
#(
  parameter int N_TELLERS = 3,
  parameter int QDEPTH = DEFAULT_QDEPTH,
  parameter int TICKET_W = DEFAULT_TICKET_W,
  parameter int ANN_CYC = 4
) (
  input logic clk,
  input logic reset,
  bank_teller_scheduler_if.slave bus
);
  localparam int CW = cw_f(QDEPTH);
  localparam int TW = tw_f(N_TELLERS);
  localparam int MW = (ANN_CYC < 2) ? 1 : $clog2(ANN_CYC);
  sched_state_t r_state, w_next;
  logic [CW-1:0] r_pcount;
  logic [TICKET_W-1:0] r_next_tkt, r_serve_tkt, r_call_ticket;
  logic [TW-1:0] r_rr_ptr, r_call_teller, w_idx;
  logic [N_TELLERS-1:0] r_busy, r_grant, w_elig, w_gnt;
  logic [MW-1:0] r_timer;
  logic r_overflow, r_call_valid;
  logic w_any, w_full, w_accept, w_start, w_end;
  assign w_full = r_pcount == CW'(QDEPTH);
  assign w_accept = bus.arrive & ~w_full;
  assign w_elig = bus.teller_req & ~r_busy;
  assign w_start = (r_state == IDLE) && (r_pcount != '0) && w_any;
  assign w_end = (r_state == ANNOUNCE) && (r_timer == '0);
  rr_arbiter #(.N(N_TELLERS), .TW(TW)) u_arb (
    .req(w_elig),
    .ptr(r_rr_ptr),
    .gnt_onehot(w_gnt),
    .gnt_idx(w_idx),
    .any(w_any)
  );
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     if (w_start) w_next = ANNOUNCE;
      ANNOUNCE: if (w_end) w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end
  // A teller stays busy until it drops its request once, so holding it high never re-grants.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pcount <= '0;
      r_next_tkt <= '0;
      r_serve_tkt <= '0;
      r_rr_ptr <= '0;
      r_busy <= '0;
      r_timer <= '0;
      r_overflow <= 1'b0;
      r_grant <= '0;
      r_call_valid <= 1'b0;
      r_call_teller <= '0;
      r_call_ticket <= '0;
    end else begin
      r_pcount <= r_pcount + CW'(w_accept) - CW'(w_start);
      r_next_tkt <= r_next_tkt + TICKET_W'(w_accept);
      r_serve_tkt <= r_serve_tkt + TICKET_W'(w_start);
      r_busy <= (r_busy & bus.teller_req) | (w_start ? w_gnt : '0);
      r_overflow <= bus.arrive & w_full;
      r_grant <= w_start ? w_gnt : '0;
      if (w_start) begin
        r_rr_ptr <= (w_idx == TW'(N_TELLERS - 1)) ? '0 : w_idx + TW'(1);
        r_timer <= MW'(ANN_CYC - 1);
        r_call_valid <= 1'b1;
        r_call_teller <= w_idx;
        r_call_ticket <= r_serve_tkt;
      end else if (r_state == ANNOUNCE) begin
        r_timer <= w_end ? '0 : r_timer - MW'(1);
        r_call_valid <= ~w_end;
      end
    end
  end
  assign bus.pcount = r_pcount;
  assign bus.full = w_full;
  assign bus.empty = r_pcount == '0;
  assign bus.overflow = r_overflow;
  assign bus.grant = r_grant;
  assign bus.call_valid = r_call_valid;
  assign bus.call_teller = r_call_teller;
  assign bus.call_ticket = r_call_ticket;
endmodule

// File: tb/tb_bank_teller_scheduler.sv
// tb_bank_teller_scheduler: scoreboard bench; expected calls queued with stimulus, checked on each grant.
module tb_bank_teller_scheduler;
  localparam int N_TELLERS = 3;
  localparam int QDEPTH = 7;
  localparam int TICKET_W = 8;
  localparam int ANN_CYC = 4;
  typedef struct packed {
    logic [1:0] teller;
    logic [7:0] ticket;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  int vcnt = 0;
  bit sb_on = 1'b1;
  exp_t sb[$];
  exp_t e;
  bank_teller_scheduler_if #(.N_TELLERS(N_TELLERS), .QDEPTH(QDEPTH), .TICKET_W(TICKET_W)) bus ();
  bank_teller_scheduler #(
    .N_TELLERS(N_TELLERS), .QDEPTH(QDEPTH), .TICKET_W(TICKET_W), .ANN_CYC(ANN_CYC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic push(input int teller, input int ticket);
    sb.push_back(exp_t'{teller: 2'(teller), ticket: 8'(ticket)});
  endtask
  task automatic wait_grant();
    for (int i = 0; i < 20; i++) begin
      if (|bus.grant) break;
      tick(1);
    end
    chk("grant_seen", 32'(|bus.grant), 1);
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 20; i++) begin
      if (!bus.call_valid) break;
      tick(1);
    end
    chk("call_end", 32'(bus.call_valid), 0);
  endtask
  task automatic do_reset();
    reset = 1'b0;
    tick(2);
    chk("rst_pcount", 32'(bus.pcount), 0);
    chk("rst_empty", 32'(bus.empty), 1);
    chk("rst_outs", {bus.full, bus.overflow, bus.grant, bus.call_valid, bus.call_teller, bus.call_ticket}, 0);
    reset = 1'b1;
    tick(1);
  endtask
  task automatic arrive_n(input int n);
    bus.arrive = 1'b1;
    tick(n);
    bus.arrive = 1'b0;
  endtask
  // Grants are pulses, so each is seen at exactly one falling edge.
  always @(negedge clk) begin
    if (!reset) vcnt = 0;
    else begin
      if (|bus.grant && sb_on) begin
        if (sb.size() == 0) chk("unexpected_grant", 32'(bus.grant), 0);
        else begin
          e = sb.pop_front();
          chk("grant", 32'(bus.grant), 32'(1) << e.teller);
          chk("call_teller", 32'(bus.call_teller), 32'(e.teller));
          chk("call_ticket", 32'(bus.call_ticket), 32'(e.ticket));
          chk("call_valid", 32'(bus.call_valid), 1);
        end
      end
      if (bus.call_valid) vcnt++;
      else if (vcnt != 0) begin
        chk("valid_len", vcnt, ANN_CYC);
        vcnt = 0;
      end
    end
  end
  assert property (@(posedge clk) disable iff (!reset)
    (8'(dut.r_pcount) == 8'(dut.r_next_tkt - dut.r_serve_tkt)) && (dut.r_pcount <= 3'(QDEPTH)))
  else chk("invariant", 32'(dut.r_pcount), 32'(8'(dut.r_next_tkt - dut.r_serve_tkt)));
  initial begin
    bus.arrive = 1'b0;
    bus.teller_req = '0;
    do_reset();
    chk("post_rst_empty", 32'(bus.empty), 1);
    chk("post_rst_valid", 32'(bus.call_valid), 0);
    // Single requesting teller picks up the first ticket.
    arrive_n(3);
    chk("pcount3", 32'(bus.pcount), 3);
    push(1, 0);
    bus.teller_req = 3'b010;
    wait_grant();
    chk("pcount_after_grant", 32'(bus.pcount), 2);
    wait_idle();
    bus.teller_req = 3'b000;
    tick(1);
    push(0, 1);
    bus.teller_req = 3'b001;
    wait_grant();
    tick(1);
    #2 reset = 1'b0;
    #1;
    chk("async_valid", 32'(bus.call_valid), 0);
    chk("async_pcount", 32'(bus.pcount), 0);
    chk("async_empty", 32'(bus.empty), 1);
    bus.teller_req = 3'b000;
    tick(2);
    reset = 1'b1;
    tick(1);
    // Round-robin across three tellers; t2 keeps its request up and must wait.
    do_reset();
    arrive_n(3);
    push(0, 0);
    push(1, 1);
    push(2, 2);
    bus.teller_req = 3'b111;
    for (int g = 0; g < 3; g++) begin
      wait_grant();
      if (g < 2) begin
        bus.teller_req[g] = 1'b0;
        tick(1);
        bus.teller_req[g] = 1'b1;
      end
      wait_idle();
    end
    chk("rr_pcount0", 32'(bus.pcount), 0);
    bus.teller_req = 3'b100;
    arrive_n(1);
    tick(10);
    chk("held_req_pcount", 32'(bus.pcount), 1);
    push(2, 3);
    bus.teller_req = 3'b000;
    tick(1);
    bus.teller_req = 3'b100;
    wait_grant();
    wait_idle();
    bus.teller_req = 3'b000;
    // Fill to capacity, overflow on the 8th, then a grant alongside a rejected arrival.
    do_reset();
    for (int k = 0; k < 8; k++) begin
      bus.arrive = 1'b1;
      tick(1);
      chk("overflow_k", 32'(bus.overflow), 32'(k == 7));
    end
    bus.arrive = 1'b0;
    tick(1);
    chk("overflow_clr", 32'(bus.overflow), 0);
    chk("full_pcount", 32'(bus.pcount), 7);
    chk("full_flag", 32'(bus.full), 1);
    push(0, 0);
    bus.teller_req = 3'b001;
    bus.arrive = 1'b1;
    tick(1);
    bus.arrive = 1'b0;
    chk("full_grant_pcount", 32'(bus.pcount), 6);
    chk("full_grant_ovf", 32'(bus.overflow), 1);
    chk("full_grant_grant", 32'(bus.grant), 1);
    wait_idle();
    bus.teller_req = 3'b000;
    // Arrival on the grant edge with one waiting.
    do_reset();
    arrive_n(1);
    chk("one_waiting", 32'(bus.pcount), 1);
    push(1, 0);
    bus.teller_req = 3'b010;
    bus.arrive = 1'b1;
    tick(1);
    bus.arrive = 1'b0;
    chk("simul_grant", 32'(bus.grant), 3'b010);
    chk("simul_pcount", 32'(bus.pcount), 1);
    wait_idle();
    push(0, 1);
    bus.teller_req = 3'b011;
    wait_grant();
    chk("simul_drain", 32'(bus.pcount), 0);
    wait_idle();
    bus.teller_req = 3'b000;
    // Long run so the ticket counter wraps through 255 -> 0.
    do_reset();
    for (int k = 0; k < 300; k++) begin
      arrive_n(1);
      push(k % 3, k % 256);
      bus.teller_req = 3'(1 << (k % 3));
      wait_grant();
      bus.teller_req = 3'b000;
      wait_idle();
    end
    chk("wrap_pcount", 32'(bus.pcount), 0);
    // Random traffic; only the invariant and window length are checked here.
    sb_on = 1'b0;
    for (int k = 0; k < 400; k++) begin
      bus.arrive = 1'($urandom_range(0, 1));
      bus.teller_req = 3'($urandom);
      tick(1);
    end
    bus.arrive = 1'b0;
    bus.teller_req = 3'b000;
    tick(8);
    do_reset();
    sb_on = 1'b1;
    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
